// File: rtl/fixed_fma_unit.sv
// ---------------------------------------------------------------------------
// fixed_fma_unit
//
// Purpose:
//   Three-stage pipelined fused multiply-add on signed Q8.24 fixed-point
//   operands. It computes (+/-)A*B (+/-)C with an exact 64-bit product and a
//   42-bit exact sum, and flags any result that does not fit in Q8.24.
//   S1 registers the operands, S2 forms the (optionally negated) product, and
//   S3 scales, adds and packs the result. S3 is the response register.
//
// Configuration:
//   RANSAC_FMA_SATURATE_EN  defined   -> overflowing results clamp to
//                                         0x7FFFFFFF / 0x80000000
//                           undefined -> overflowing results wrap (low 32 bits
//                                         of the exact sum)
//   rsp_overflow behaves identically in both builds.
//
// Ports:
//   clk           rising-edge clock for all state
//   rst           asynchronous active-high reset
//   req_valid     request present
//   req_ready     block accepts a request this cycle (equals !stall)
//   req_opcode    0: A*B+C  1: A*B-C  2: -A*B+C  3: -A*B-C
//   req_a/b/c     signed Q8.24 operands
//   req_tag       opaque ID returned with the result
//   rsp_valid     result present
//   rsp_ready     consumer accepts the result this cycle
//   rsp_result    signed Q8.24 result
//   rsp_tag       tag of the request that produced rsp_result
//   rsp_overflow  exact result not representable in Q8.24
//   busy          any pipeline stage holds a valid entry
// ---------------------------------------------------------------------------
module fixed_fma_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_opcode,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [31:0] req_c,
  input  logic [3:0]  req_tag,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_tag,
  output logic        rsp_overflow,
  output logic        busy
);

  typedef enum logic [1:0] {
    OP_FMA_ADD  = 2'd0,
    OP_FMA_SUB  = 2'd1,
    OP_NFMA_ADD = 2'd2,
    OP_NFMA_SUB = 2'd3
  } fma_opcode_t;

  typedef logic [31:0] fixed_t;

  // Stage 1: registered operands
  logic        s1_valid_q, s1_valid_d;
  fma_opcode_t s1_op_q,    s1_op_d;
  fixed_t      s1_a_q,     s1_a_d;
  fixed_t      s1_b_q,     s1_b_d;
  fixed_t      s1_c_q,     s1_c_d;
  logic [3:0]  s1_tag_q,   s1_tag_d;

  // Stage 2: signed 64-bit product (already negated when requested)
  logic        s2_valid_q, s2_valid_d;
  logic [63:0] s2_prod_q,  s2_prod_d;
  logic        s2_sub_q,   s2_sub_d;
  fixed_t      s2_c_q,     s2_c_d;
  logic [3:0]  s2_tag_q,   s2_tag_d;

  // Stage 3: packed result, doubles as the response register
  logic        s3_valid_q,  s3_valid_d;
  fixed_t      s3_result_q, s3_result_d;
  logic [3:0]  s3_tag_q,    s3_tag_d;
  logic        s3_ovf_q,    s3_ovf_d;

  // Datapath intermediates
  logic        stall;
  logic        negate;
  logic [63:0] mult_a;
  logic [63:0] mult_b;
  logic [63:0] product;
  logic [63:0] product_signed;
  logic [41:0] scaled;
  logic [41:0] c_ext;
  logic [41:0] sum;
  logic        sum_overflow;
  fixed_t      packed_result;

  // The pipeline never compresses bubbles, so one stall signal freezes
  // every stage at once. req_ready depends only on registered state and
  // rsp_ready, never on req_valid.
  assign stall     = s3_valid_q && !rsp_ready;
  assign req_ready = !stall;

  assign rsp_valid    = s3_valid_q;
  assign rsp_result   = s3_result_q;
  assign rsp_tag      = s3_tag_q;
  assign rsp_overflow = s3_ovf_q;
  assign busy         = s1_valid_q || s2_valid_q || s3_valid_q;

  // Product stage: sign-extending both operands to 64 bits makes an
  // unsigned 64x64 multiply yield the exact signed product in the low
  // 64 bits. Negation is applied to the whole product so that the later
  // floor shift rounds the negated value, not the magnitude.
  always_comb begin
    mult_a         = {{32{s1_a_q[31]}}, s1_a_q};
    mult_b         = {{32{s1_b_q[31]}}, s1_b_q};
    product        = mult_a * mult_b;
    negate         = (s1_op_q == OP_NFMA_ADD) || (s1_op_q == OP_NFMA_SUB);
    product_signed = negate ? (64'd0 - product) : product;
  end

  // Scale/add/pack stage: the arithmetic shift floors toward negative
  // infinity; 42 bits hold |A*B|>>24 (<= 2^38) plus |C| (<= 2^31) exactly.
  // The sum is in range only when bits 41..31 are all copies of bit 31.
  always_comb begin
    scaled       = 42'($signed(s2_prod_q) >>> 24);
    c_ext        = {{10{s2_c_q[31]}}, s2_c_q};
    sum          = s2_sub_q ? (scaled - c_ext) : (scaled + c_ext);
    sum_overflow = (sum[41:31] != {11{sum[31]}});
`ifdef RANSAC_FMA_SATURATE_EN
    if (sum_overflow) begin
      packed_result = sum[41] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      packed_result = sum[31:0];
    end
`else
    packed_result = sum[31:0];
`endif
  end

  // Next-state for all three stages. Everything holds while stalled;
  // otherwise every stage (valid or bubble) moves one step forward.
  // Payload registers only load when a valid entry arrives.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_c_d      = s1_c_q;
    s1_tag_d    = s1_tag_q;
    s2_valid_d  = s2_valid_q;
    s2_prod_d   = s2_prod_q;
    s2_sub_d    = s2_sub_q;
    s2_c_d      = s2_c_q;
    s2_tag_d    = s2_tag_q;
    s3_valid_d  = s3_valid_q;
    s3_result_d = s3_result_q;
    s3_tag_d    = s3_tag_q;
    s3_ovf_d    = s3_ovf_q;

    if (!stall) begin
      s1_valid_d = req_valid;
      if (req_valid) begin
        s1_op_d  = fma_opcode_t'(req_opcode);
        s1_a_d   = req_a;
        s1_b_d   = req_b;
        s1_c_d   = req_c;
        s1_tag_d = req_tag;
      end

      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_prod_d = product_signed;
        s2_sub_d  = (s1_op_q == OP_FMA_SUB) || (s1_op_q == OP_NFMA_SUB);
        s2_c_d    = s1_c_q;
        s2_tag_d  = s1_tag_q;
      end

      s3_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        s3_result_d = packed_result;
        s3_tag_d    = s2_tag_q;
        s3_ovf_d    = sum_overflow;
      end
    end
  end

  // State registers. Reset clears every stage so in-flight entries are
  // discarded and the response outputs read as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= OP_FMA_ADD;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_c_q      <= '0;
      s1_tag_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_prod_q   <= '0;
      s2_sub_q    <= 1'b0;
      s2_c_q      <= '0;
      s2_tag_q    <= '0;
      s3_valid_q  <= 1'b0;
      s3_result_q <= '0;
      s3_tag_q    <= '0;
      s3_ovf_q    <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_c_q      <= s1_c_d;
      s1_tag_q    <= s1_tag_d;
      s2_valid_q  <= s2_valid_d;
      s2_prod_q   <= s2_prod_d;
      s2_sub_q    <= s2_sub_d;
      s2_c_q      <= s2_c_d;
      s2_tag_q    <= s2_tag_d;
      s3_valid_q  <= s3_valid_d;
      s3_result_q <= s3_result_d;
      s3_tag_q    <= s3_tag_d;
      s3_ovf_q    <= s3_ovf_d;
    end
  end

endmodule

// File: tb/tb_fixed_fma_unit.sv
// ---------------------------------------------------------------------------
// tb_fixed_fma_unit
//
// Self-checking bench for fixed_fma_unit. A reference model computes each
// expected response with plain 64-bit integer arithmetic, and a scoreboard
// queue holds the results in acceptance order. Directed vectors cover the
// documented examples, backpressure and mid-flight reset. A randomized phase
// then mixes operand ranges, request gaps and rsp_ready backpressure.
// Define RANSAC_FMA_SATURATE_EN to check the saturating build.
// ---------------------------------------------------------------------------
module tb_fixed_fma_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        reqValid;
   logic        reqReady;
   logic [1:0]  reqOpcode;
   logic [31:0] reqA;
   logic [31:0] reqB;
   logic [31:0] reqC;
   logic [3:0]  reqTag;
   logic        rspValid;
   logic        rspReady;
   logic [31:0] rspResult;
   logic [3:0]  rspTag;
   logic        rspOverflow;
   logic        busy;

   typedef struct {
      logic [31:0] result;
      logic [3:0]  tag;
      logic        overflow;
   } expEntryT;

   expEntryT expQ[$];
   int       checkCount = 0;
   int       passCount  = 0;
   bit       randomBp   = 1'b0;

`ifdef RANSAC_FMA_SATURATE_EN
   localparam logic [31:0] OvfExample = 32'h7FFF_FFFF;
`else
   localparam logic [31:0] OvfExample = 32'hC800_0000;
`endif

   fixed_fma_unit dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (reqValid),
      .req_ready    (reqReady),
      .req_opcode   (reqOpcode),
      .req_a        (reqA),
      .req_b        (reqB),
      .req_c        (reqC),
      .req_tag      (reqTag),
      .rsp_valid    (rspValid),
      .rsp_ready    (rspReady),
      .rsp_result   (rspResult),
      .rsp_tag      (rspTag),
      .rsp_overflow (rspOverflow),
      .busy         (busy)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string name, input logic [63:0] observed,
                              input logic [63:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t",
                  name, observed, expected, $time);
      end
   endtask

   // Reference model: exact value of (+/-)A*B floored by 2^24, then (+/-)C
   function automatic expEntryT computeExpected(input logic [1:0] op,
                                                input logic [31:0] a,
                                                input logic [31:0] b,
                                                input logic [31:0] c,
                                                input logic [3:0] tag);
      longint   pa, pb, pc, prod, scaledVal, sumVal;
      expEntryT e;
      pa = longint'($signed(a));
      pb = longint'($signed(b));
      pc = longint'($signed(c));
      prod = pa * pb;
      if (op >= 2'd2) prod = -prod;
      scaledVal = prod >>> 24;
      sumVal = op[0] ? (scaledVal - pc) : (scaledVal + pc);
      e.tag = tag;
      e.overflow = (sumVal > 64'sd2147483647) || (sumVal < -64'sd2147483648);
`ifdef RANSAC_FMA_SATURATE_EN
      if (e.overflow) e.result = (sumVal < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
      else e.result = sumVal[31:0];
`else
      e.result = sumVal[31:0];
`endif
      return e;
   endfunction

   // Random operand drawn from several magnitude bands plus the extremes
   function automatic logic [31:0] randOperand();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 3))
         0: return r;
         1: return {{5{r[27]}}, r[26:0]};
         2: return {{9{r[22]}}, r[22:0]};
         default: return ($urandom_range(0, 1) != 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      endcase
   endfunction

   // Scoreboard: record accepted requests and compare delivered responses,
   // sampled on the falling edge while inputs are stable
   always @(negedge clk) begin : scoreboard
      expEntryT e;
      if (!rst) begin
         if (rspValid && rspReady) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpectedRsp", 64'(rspValid), 64'd0);
            end else begin
               e = expQ.pop_front();
               checkOutput("rspTag", 64'(rspTag), 64'(e.tag));
               checkOutput("rspResult", 64'(rspResult), 64'(e.result));
               checkOutput("rspOverflow", 64'(rspOverflow), 64'(e.overflow));
            end
         end
         if (reqValid && reqReady) begin
            expQ.push_back(computeExpected(reqOpcode, reqA, reqB, reqC, reqTag));
         end
      end
   end

   // Randomized consumer backpressure during the random phase
   always @(posedge clk) begin
      if (randomBp) begin
         #1;
         rspReady = ($urandom_range(0, 3) != 0);
      end
   end

   // Present one request and hold it until accepted. Called and returns
   // 1 ns after a rising edge.
   task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] c,
                                input logic [3:0] tag);
      int waitCycles = 0;
      reqOpcode = op;
      reqA      = a;
      reqB      = b;
      reqC      = c;
      reqTag    = tag;
      reqValid  = 1'b1;
      @(negedge clk);
      while (!reqReady && waitCycles < 100) begin
         @(negedge clk);
         waitCycles++;
      end
      if (!reqReady) checkOutput("acceptTimeout", 64'(reqReady), 64'd1);
      @(posedge clk);
      #1;
      reqValid = 1'b0;
   endtask

   // Send one request into an idle pipeline and check both the response
   // latency (rising on the third edge counting the accepting edge) and
   // the response against spec-given constants
   task automatic sendAndTime(input logic [1:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] c,
                              input logic [3:0] tag, input logic [31:0] expResult,
                              input logic expOverflow, input string name);
      int n = 0;
      applyStimulus(op, a, b, c, tag);
      do begin
         @(negedge clk);
         n++;
      end while (!rspValid && n < 10);
      checkOutput({name, "Latency"}, 64'(n), 64'd3);
      checkOutput({name, "Result"}, 64'(rspResult), 64'(expResult));
      checkOutput({name, "Tag"}, 64'(rspTag), 64'(tag));
      checkOutput({name, "Overflow"}, 64'(rspOverflow), 64'(expOverflow));
      @(posedge clk);
      #1;
   endtask

   // Wait for the pipeline and scoreboard to drain, bounded
   task automatic waitIdle();
      int n = 0;
      while ((busy || expQ.size() != 0) && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("idleBusy", 64'(busy), 64'd0);
      checkOutput("idleQueue", 64'(expQ.size()), 64'd0);
   endtask

   initial begin
      rst       = 1'b1;
      reqValid  = 1'b0;
      reqOpcode = 2'd0;
      reqA      = '0;
      reqB      = '0;
      reqC      = '0;
      reqTag    = '0;
      rspReady  = 1'b1;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      checkOutput("resetRspValid", 64'(rspValid), 64'd0);
      checkOutput("resetBusy", 64'(busy), 64'd0);
      checkOutput("resetReqReady", 64'(reqReady), 64'd1);
      checkOutput("resetResult", 64'(rspResult), 64'd0);
      checkOutput("resetTag", 64'(rspTag), 64'd0);
      checkOutput("resetOverflow", 64'(rspOverflow), 64'd0);

      // Release and request in the same cycle: accepted on the first edge
      rst = 1'b0;
      sendAndTime(2'd0, 32'h0180_0000, 32'h0200_0000, 32'h0040_0000, 4'd3,
                  32'h0340_0000, 1'b0, "basic");
      waitIdle();
      sendAndTime(2'd3, 32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 4'd5,
                  32'hFE00_0000, 1'b0, "negate");
      waitIdle();
      sendAndTime(2'd0, 32'hFFFF_FFFF, 32'h0080_0000, 32'h0000_0000, 4'd6,
                  32'hFFFF_FFFF, 1'b0, "truncate");
      waitIdle();
      sendAndTime(2'd0, 32'h6400_0000, 32'h0200_0000, 32'h0000_0000, 4'd7,
                  OvfExample, 1'b1, "overflow");
      waitIdle();

      // Backpressure: fill the pipeline with the consumer stalled
      $display("[TB] backpressure phase");
      rspReady = 1'b0;
      for (int t = 0; t < 3; t++) begin
         applyStimulus(2'(t), 32'h0010_0000 * (t + 1), 32'h0300_0000,
                       32'h0020_0000, 4'(t));
      end
      reqOpcode = 2'd3;
      reqA      = 32'h0040_0000;
      reqB      = 32'h0300_0000;
      reqC      = 32'h0020_0000;
      reqTag    = 4'd3;
      reqValid  = 1'b1;
      repeat (5) begin
         @(negedge clk);
         checkOutput("stallReqReady", 64'(reqReady), 64'd0);
         checkOutput("stallRspValid", 64'(rspValid), 64'd1);
         checkOutput("stallBusy", 64'(busy), 64'd1);
         if (expQ.size() > 0) begin
            checkOutput("stallTag", 64'(rspTag), 64'(expQ[0].tag));
            checkOutput("stallResult", 64'(rspResult), 64'(expQ[0].result));
            checkOutput("stallOverflow", 64'(rspOverflow), 64'(expQ[0].overflow));
         end
      end
      checkOutput("stallQueueDepth", 64'(expQ.size()), 64'd3);
      @(posedge clk);
      #1;
      rspReady = 1'b1;
      applyStimulus(2'd3, 32'h0040_0000, 32'h0300_0000, 32'h0020_0000, 4'd3);
      waitIdle();

      // Reset with two entries in flight
      $display("[TB] mid-flight reset phase");
      applyStimulus(2'd0, 32'h0100_0000, 32'h0100_0000, 32'h0000_0000, 4'd8);
      applyStimulus(2'd1, 32'h0200_0000, 32'h0100_0000, 32'h0000_0000, 4'd9);
      rst = 1'b1;
      #1;
      checkOutput("midResetRspValid", 64'(rspValid), 64'd0);
      checkOutput("midResetBusy", 64'(busy), 64'd0);
      checkOutput("midResetReqReady", 64'(reqReady), 64'd1);
      expQ.delete();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      checkOutput("postResetBusy", 64'(busy), 64'd0);
      sendAndTime(2'd1, 32'h0200_0000, 32'h0100_0000, 32'h0080_0000, 4'd10,
                  32'h0180_0000, 1'b0, "postReset");
      waitIdle();

      // Randomized traffic with random gaps and random backpressure
      $display("[TB] random phase");
      randomBp = 1'b1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end else begin
            applyStimulus(2'($urandom_range(0, 3)), randOperand(), randOperand(),
                          randOperand(), 4'($urandom_range(0, 15)));
         end
      end
      randomBp = 1'b0;
      @(posedge clk);
      #2;
      rspReady = 1'b1;
      waitIdle();

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
